// File: rtl/csr_file.sv
`default_nettype none
// ============================================================================
// Module   : csr_file
// Purpose  : Machine-mode CSR block. Holds mstatus, mie, mtvec, mepc, mcause
//            and a read-only mip; takes timer/external interrupts and MRET,
//            producing a single-cycle redirect request to the fetch stage.
// Ports    : clk, rst (async, active-low)
//            stall           - freezes CSR state, blocks redirects
//            instruction     - [31:20] carries the CSR address
//            csr_reg_r/_wr   - read enable / CSRRW write enable
//            is_mret         - MRET in this stage
//            wdata, pc       - rs1 write value, PC of this instruction
//            timer_irq/ext_irq - asynchronous interrupt levels
//            rdata           - CSR read data (combinational)
//            epc_taken, epc  - redirect request and target
// Revision : 1.0 - initial release
// ============================================================================
module csr_file (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [31:0] instruction,
  input  logic        csr_reg_r,
  input  logic        csr_reg_wr,
  input  logic        is_mret,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  input  logic        timer_irq,
  input  logic        ext_irq,
  output logic [31:0] rdata,
  output logic        epc_taken,
  output logic [31:0] epc
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MIP     = 12'h344;

  localparam logic [3:0] CAUSE_TIMER = 4'd7;
  localparam logic [3:0] CAUSE_EXT   = 4'd11;

  // Architectural state; only implemented bits are stored.
  logic        mstatus_mie;
  logic        mstatus_mpie;
  logic        mie_mtie;
  logic        mie_meie;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic [31:0] mcause;

  // Two-flop synchronisers for the asynchronous interrupt levels
  logic        timer_s1, timer_s2;
  logic        ext_s1, ext_s2;

  logic [11:0] addr;
  logic [31:0] csr_val;
  logic        timer_pend;
  logic        ext_pend;
  logic        irq_pending;
  logic        take_trap;
  logic        take_mret;
  logic        wr_en;
  logic [3:0]  cause;
  logic [31:0] vec_base;

  // Low instruction bits carry no CSR information here.
  logic        unused_instr_bits;
  assign unused_instr_bits = ^instruction[19:0];

  assign addr = instruction[31:20];

  always_comb begin
    csr_val = 32'h0;
    case (addr)
      ADDR_MSTATUS: csr_val = {24'h0, mstatus_mpie, 3'b000, mstatus_mie, 3'b000};
      ADDR_MIE:     csr_val = {20'h0, mie_meie, 3'b000, mie_mtie, 7'h00};
      ADDR_MTVEC:   csr_val = mtvec;
      ADDR_MEPC:    csr_val = mepc;
      ADDR_MCAUSE:  csr_val = mcause;
      ADDR_MIP:     csr_val = {20'h0, ext_s2, 3'b000, timer_s2, 7'h00};
      default:      csr_val = 32'h0;
    endcase
  end

  // Read returns the pre-write value; any write lands on the clock edge.
  assign rdata = csr_reg_r ? csr_val : 32'h0;

  assign timer_pend  = timer_s2 & mie_mtie;
  assign ext_pend    = ext_s2 & mie_meie;
  assign irq_pending = mstatus_mie & (timer_pend | ext_pend);

  // MRET wins over a coincident interrupt; the interrupt is re-examined
  // next cycle against the MIE restored by MRET.
  assign take_mret = is_mret & ~stall;
  assign take_trap = irq_pending & ~stall & ~is_mret;

  // The instruction in a trap-entry cycle is flushed, so its write is dropped.
  assign wr_en = csr_reg_wr & ~stall & ~take_trap;

  assign cause    = ext_pend ? CAUSE_EXT : CAUSE_TIMER;
  assign vec_base = {mtvec[31:2], 2'b00};

  always_comb begin
    epc_taken = 1'b0;
    epc       = 32'h0;
    if (take_mret) begin
      epc_taken = 1'b1;
      epc       = mepc;
    end else if (take_trap) begin
      epc_taken = 1'b1;
      epc       = mtvec[0] ? (vec_base + {26'h0, cause, 2'b00}) : vec_base;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_s1 <= 1'b0;
      timer_s2 <= 1'b0;
      ext_s1   <= 1'b0;
      ext_s2   <= 1'b0;
    end else begin
      timer_s1 <= timer_irq;
      timer_s2 <= timer_s1;
      ext_s1   <= ext_irq;
      ext_s2   <= ext_s1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_mtie     <= 1'b0;
      mie_meie     <= 1'b0;
      mtvec        <= 32'h0;
      mepc         <= 32'h0;
      mcause       <= 32'h0;
    end else if (!stall) begin
      if (take_trap) begin
        mepc         <= pc;
        mcause       <= {1'b1, 27'h0, cause};
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
      end else begin
        if (wr_en) begin
          case (addr)
            ADDR_MSTATUS: begin
              mstatus_mie  <= wdata[3];
              mstatus_mpie <= wdata[7];
            end
            ADDR_MIE: begin
              mie_mtie <= wdata[7];
              mie_meie <= wdata[11];
            end
            ADDR_MTVEC:  mtvec  <= {wdata[31:2], 1'b0, wdata[0]};
            ADDR_MEPC:   mepc   <= {wdata[31:2], 2'b00};
            ADDR_MCAUSE: mcause <= wdata;
            default: ;
          endcase
        end
        // MRET's effect on mstatus overrides a same-cycle mstatus write.
        if (take_mret) begin
          mstatus_mie  <= mstatus_mpie;
          mstatus_mpie <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_csr_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_csr_file
// Purpose  : Directed self-checking bench for csr_file. Inputs change on the
//            falling edge; outputs are sampled 1 ns later, well before the
//            next rising edge that commits state.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csr_file;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] instruction = 32'h0;
  logic        csr_reg_r = 1'b0;
  logic        csr_reg_wr = 1'b0;
  logic        is_mret = 1'b0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] pc = 32'h0;
  logic        timer_irq = 1'b0;
  logic        ext_irq = 1'b0;
  logic [31:0] rdata;
  logic        epc_taken;
  logic [31:0] epc;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  csr_file dut (
    .clk(clk), .rst(rst), .stall(stall), .instruction(instruction),
    .csr_reg_r(csr_reg_r), .csr_reg_wr(csr_reg_wr), .is_mret(is_mret),
    .wdata(wdata), .pc(pc), .timer_irq(timer_irq), .ext_irq(ext_irq),
    .rdata(rdata), .epc_taken(epc_taken), .epc(epc)
  );

  // One pipeline cycle of stimulus; returns 1 ns after the falling edge.
  task automatic drive(input logic [11:0] a, input logic r, input logic w,
                       input logic [31:0] d, input logic m, input logic s,
                       input logic [31:0] p);
    @(negedge clk);
    instruction = {a, 20'h00073};
    csr_reg_r   = r;
    csr_reg_wr  = w;
    wdata       = d;
    is_mret     = m;
    stall       = s;
    pc          = p;
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    drive(a, 1'b0, 1'b1, d, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] v);
    drive(a, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    v = rdata;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(12'h000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_reset();
    logic [11:0] addrs [6];
    logic [31:0] v;
    addrs = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344};
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rd(addrs[i], v);
      n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL reset_csr_%h: got %h expected %h", addrs[i], v, 32'h0); end
    end
    n_cmp++; if (epc_taken !== 1'b0 || epc !== 32'h0) begin n_bad++; $display("FAIL reset_redirect: got %b/%h expected 0/0", epc_taken, epc); end
    @(negedge clk); rst = 1'b1;
    idle(1);
  endtask

  task automatic test_write_read();
    logic [31:0] v;
    wr(12'h305, 32'h0000_0103); rd(12'h305, v);
    n_cmp++; if (v !== 32'h0000_0101) begin n_bad++; $display("FAIL mtvec_wr_rd: got %h expected %h", v, 32'h101); end
    wr(12'h341, 32'h0000_0047); rd(12'h341, v);
    n_cmp++; if (v !== 32'h0000_0044) begin n_bad++; $display("FAIL mepc_align: got %h expected %h", v, 32'h44); end
    wr(12'h344, 32'hFFFF_FFFF); rd(12'h344, v);
    n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL mip_ro: got %h expected %h", v, 32'h0); end
    wr(12'h300, 32'hFFFF_FFFF); rd(12'h300, v);
    n_cmp++; if (v !== 32'h0000_0088) begin n_bad++; $display("FAIL mstatus_mask: got %h expected %h", v, 32'h88); end
    wr(12'h304, 32'hFFFF_FFFF); rd(12'h304, v);
    n_cmp++; if (v !== 32'h0000_0880) begin n_bad++; $display("FAIL mie_mask: got %h expected %h", v, 32'h880); end
    wr(12'h342, 32'h1234_5678); rd(12'h342, v);
    n_cmp++; if (v !== 32'h1234_5678) begin n_bad++; $display("FAIL mcause_wr_rd: got %h expected %h", v, 32'h12345678); end
    wr(12'h340, 32'hDEAD_BEEF); rd(12'h340, v);
    n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL unimpl_csr: got %h expected %h", v, 32'h0); end
    drive(12'h305, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL read_disabled: got %h expected %h", rdata, 32'h0); end
    // Read and write together: old value visible, new value next cycle
    drive(12'h305, 1'b1, 1'b1, 32'h0000_0200, 1'b0, 1'b0, 32'h0);
    n_cmp++; if (rdata !== 32'h0000_0101) begin n_bad++; $display("FAIL rw_old_value: got %h expected %h", rdata, 32'h101); end
    rd(12'h305, v);
    n_cmp++; if (v !== 32'h0000_0200) begin n_bad++; $display("FAIL rw_new_value: got %h expected %h", v, 32'h200); end
    wr(12'h300, 32'h0); wr(12'h304, 32'h0);
  endtask

  task automatic test_timer_trap();
    logic [31:0] v;
    wr(12'h305, 32'h0000_0100); wr(12'h304, 32'h0000_0080); wr(12'h300, 32'h0000_0008);
    drive(12'h000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h1000);
    timer_irq = 1'b1;
    n_cmp++; if (epc_taken !== 1'b0) begin n_bad++; $display("FAIL timer_sync_0: got %b expected 0", epc_taken); end
    drive(12'h000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h1004);
    n_cmp++; if (epc_taken !== 1'b0) begin n_bad++; $display("FAIL timer_sync_1: got %b expected 0", epc_taken); end
    drive(12'h000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h1008);
    n_cmp++; if (epc_taken !== 1'b1 || epc !== 32'h100) begin n_bad++; $display("FAIL timer_trap: got %b/%h expected 1/%h", epc_taken, epc, 32'h100); end
    drive(12'h000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0100);
    n_cmp++; if (epc_taken !== 1'b0 || epc !== 32'h0) begin n_bad++; $display("FAIL timer_single_pulse: got %b/%h expected 0/0", epc_taken, epc); end
    rd(12'h341, v);
    n_cmp++; if (v !== 32'h0000_1008) begin n_bad++; $display("FAIL timer_mepc: got %h expected %h", v, 32'h1008); end
    rd(12'h342, v);
    n_cmp++; if (v !== 32'h8000_0007) begin n_bad++; $display("FAIL timer_mcause: got %h expected %h", v, 32'h80000007); end
    rd(12'h300, v);
    n_cmp++; if (v !== 32'h0000_0080) begin n_bad++; $display("FAIL timer_mstatus: got %h expected %h", v, 32'h80); end
    rd(12'h344, v);
    n_cmp++; if (v !== 32'h0000_0080) begin n_bad++; $display("FAIL mip_timer: got %h expected %h", v, 32'h80); end
  endtask

  task automatic test_vectored();
    logic [31:0] v;
    ext_irq = 1'b1;
    wr(12'h305, 32'h0000_0201); wr(12'h304, 32'h0000_0880);
    idle(2);
    wr(12'h300, 32'h0000_0008);
    drive(12'h000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h2000);
    n_cmp++; if (epc_taken !== 1'b1 || epc !== 32'h22C) begin n_bad++; $display("FAIL vec_trap: got %b/%h expected 1/%h", epc_taken, epc, 32'h22C); end
    rd(12'h342, v);
    n_cmp++; if (v !== 32'h8000_000B) begin n_bad++; $display("FAIL vec_mcause: got %h expected %h", v, 32'h8000000B); end
    rd(12'h341, v);
    n_cmp++; if (v !== 32'h0000_2000) begin n_bad++; $display("FAIL vec_mepc: got %h expected %h", v, 32'h2000); end
  endtask

  task automatic test_mret();
    logic [31:0] v;
    timer_irq = 1'b0; ext_irq = 1'b0;
    idle(3);
    wr(12'h341, 32'h0000_0044);
    drive(12'h000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    n_cmp++; if (epc_taken !== 1'b1 || epc !== 32'h44) begin n_bad++; $display("FAIL mret_redirect: got %b/%h expected 1/%h", epc_taken, epc, 32'h44); end
    rd(12'h300, v);
    n_cmp++; if (v !== 32'h0000_0088) begin n_bad++; $display("FAIL mret_mstatus: got %h expected %h", v, 32'h88); end
    n_cmp++; if (epc_taken !== 1'b0) begin n_bad++; $display("FAIL mret_single_pulse: got %b expected 0", epc_taken); end
  endtask

  task automatic test_mret_with_irq();
    logic [31:0] v;
    wr(12'h304, 32'h0);
    timer_irq = 1'b1;
    idle(3);
    wr(12'h341, 32'h0000_0080);
    wr(12'h304, 32'h0000_0080);
    drive(12'h000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h3000);
    n_cmp++; if (epc_taken !== 1'b1 || epc !== 32'h80) begin n_bad++; $display("FAIL mret_priority: got %b/%h expected 1/%h", epc_taken, epc, 32'h80); end
    // Trap cycle also carries a CSR write that must be dropped
    drive(12'h305, 1'b0, 1'b1, 32'h0000_0999, 1'b0, 1'b0, 32'h3004);
    n_cmp++; if (epc_taken !== 1'b1 || epc !== 32'h21C) begin n_bad++; $display("FAIL trap_after_mret: got %b/%h expected 1/%h", epc_taken, epc, 32'h21C); end
    rd(12'h341, v);
    n_cmp++; if (v !== 32'h0000_3004) begin n_bad++; $display("FAIL trap_after_mret_mepc: got %h expected %h", v, 32'h3004); end
    rd(12'h342, v);
    n_cmp++; if (v !== 32'h8000_0007) begin n_bad++; $display("FAIL trap_after_mret_mcause: got %h expected %h", v, 32'h80000007); end
    rd(12'h305, v);
    n_cmp++; if (v !== 32'h0000_0201) begin n_bad++; $display("FAIL trap_write_suppressed: got %h expected %h", v, 32'h201); end
  endtask

  task automatic test_stall();
    logic [31:0] v;
    wr(12'h300, 32'h0000_0008);
    drive(12'h305, 1'b0, 1'b1, 32'h0000_0400, 1'b0, 1'b1, 32'h4000);
    n_cmp++; if (epc_taken !== 1'b0 || epc !== 32'h0) begin n_bad++; $display("FAIL stall_no_trap: got %b/%h expected 0/0", epc_taken, epc); end
    drive(12'h341, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h4004);
    n_cmp++; if (epc_taken !== 1'b0 || rdata !== 32'h3004) begin n_bad++; $display("FAIL stall_mret_blocked: got %b/%h expected 0/%h", epc_taken, rdata, 32'h3004); end
    drive(12'h305, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h5000);
    n_cmp++; if (rdata !== 32'h0000_0201) begin n_bad++; $display("FAIL stall_write_frozen: got %h expected %h", rdata, 32'h201); end
    n_cmp++; if (epc_taken !== 1'b1 || epc !== 32'h21C) begin n_bad++; $display("FAIL trap_after_stall: got %b/%h expected 1/%h", epc_taken, epc, 32'h21C); end
    rd(12'h341, v);
    n_cmp++; if (v !== 32'h0000_5000) begin n_bad++; $display("FAIL trap_after_stall_mepc: got %h expected %h", v, 32'h5000); end
  endtask

  task automatic test_reset_mid();
    logic [11:0] addrs [6];
    logic [31:0] v;
    addrs = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344};
    rd(12'h305, v);
    n_cmp++; if (v !== 32'h0000_0201) begin n_bad++; $display("FAIL pre_reset_mtvec: got %h expected %h", v, 32'h201); end
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL async_reset_mtvec: got %h expected %h", rdata, 32'h0); end
    for (int i = 0; i < 6; i++) begin
      rd(addrs[i], v);
      n_cmp++; if (v !== 32'h0 || epc_taken !== 1'b0) begin n_bad++; $display("FAIL mid_reset_%h: got %h/%b expected 0/0", addrs[i], v, epc_taken); end
    end
    timer_irq = 1'b0;
    @(negedge clk); rst = 1'b1;
    wr(12'h305, 32'h0000_0010); rd(12'h305, v);
    n_cmp++; if (v !== 32'h0000_0010) begin n_bad++; $display("FAIL post_reset_resume: got %h expected %h", v, 32'h10); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_read();
    test_timer_trap();
    test_vectored();
    test_mret();
    test_mret_with_irq();
    test_stall();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
